pixel_stream_tx: RTL and testbench

Raster pixel source that feeds the 3x3 window/convolution path. It reads a stored RGB frame from a single-port frame memory with 1-cycle read latency. It then emits a continuous, line-ordered 8-bit R/G/B stream with valid and frame/line markers. Horizontal blanking cycles carry zero pixels so that the downstream line-buffered window generator sees zero padding between lines. Optionally, two trailing zero lines flush its line buffers.

---
 rtl/pixel_stream_tx_if.sv | 28 ++
 rtl/pixel_stream_tx.sv | 190 +++++++++++++++++++
 tb/tb_pixel_stream_tx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_tx_if.sv
`timescale 1ns/1ps
// Frame-memory read port and RGB pixel stream of pixel_stream_tx.
// master = the pixel source side, slave = memory / downstream side.
interface pixel_stream_tx_if #(
    parameter int ADDR_W = 12
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rdata;
    logic [7:0]        dataR;
    logic [7:0]        dataG;
    logic [7:0]        dataB;
    logic              pix_valid;
    logic              sof;
    logic              eol;
    logic              sol;
    logic              eof;

    modport master (
        output mem_rd, mem_addr, dataR, dataG, dataB, pix_valid, sof, eol, sol, eof,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd, mem_addr, dataR, dataG, dataB, pix_valid, sof, eol, sol, eof,
        output mem_rdata
    );
endinterface

// File: rtl/pixel_stream_tx.sv
`timescale 1ns/1ps
// Raster RGB pixel source: reads a frame from 1-cycle-latency memory and streams it line by line
// with zero-filled horizontal blanking. Macro PIXEL_STREAM_TX_FLUSH_EN appends two zero lines.
module pixel_stream_tx #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int HBLANK = 4,
    parameter int ADDR_W = 12
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic busy,
    output logic done,
    pixel_stream_tx_if.master bus
);
    localparam int LINE_P = IMG_W + HBLANK;
    localparam int XW     = $clog2(LINE_P);
    localparam int HW     = $clog2(HBLANK);
    localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HBLANK - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
`ifdef PIXEL_STREAM_TX_FLUSH_EN
    localparam logic [XW-1:0] P_LAST = XW'(LINE_P - 1);
`endif

    typedef enum logic [2:0] {S_IDLE, S_LINE, S_HBLANK, S_FLUSH, S_FIN} state_t;

    typedef struct packed {
        logic vld;
        logic sof;
        logic sol;
        logic eol;
        logic eof;
        logic fl;
    } tag_t;

    state_t            state, state_nxt;
    logic [XW-1:0]     x;
    logic [HW-1:0]     hb;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
`ifdef PIXEL_STREAM_TX_FLUSH_EN
    logic              fl_ln;
`endif

    tag_t        tag_p0, tag_p1;
    logic [7:0]  r_p2, g_p2, b_p2;
    logic        vld_p2;
    logic [3:0]  mrk_p2;

    function automatic logic [23:0] pix_gate(input logic [23:0] rdata, input logic real_px);
        return real_px ? rdata : 24'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        bus.mem_rd = 1'b0;
        tag_p0     = '0;
        case (state)
            S_IDLE: if (start) state_nxt = S_LINE;
            S_LINE: begin
                busy       = 1'b1;
                bus.mem_rd = 1'b1;
                tag_p0.vld = 1'b1;
                tag_p0.sol = (x == '0);
                tag_p0.eol = (x == X_LAST);
                tag_p0.sof = (x == '0) && (y == '0);
`ifndef PIXEL_STREAM_TX_FLUSH_EN
                tag_p0.eof = (x == X_LAST) && (y == Y_LAST);
`endif
                if (x == X_LAST) state_nxt = S_HBLANK;
            end
            S_HBLANK: begin
                busy = 1'b1;
                if (hb == H_LAST) begin
`ifdef PIXEL_STREAM_TX_FLUSH_EN
                    state_nxt = (y == Y_LAST) ? S_FLUSH : S_LINE;
`else
                    state_nxt = (y == Y_LAST) ? S_FIN : S_LINE;
`endif
                end
            end
`ifdef PIXEL_STREAM_TX_FLUSH_EN
            S_FLUSH: begin
                busy = 1'b1;
                if (x <= X_LAST) begin
                    tag_p0.vld = 1'b1;
                    tag_p0.fl  = 1'b1;
                    tag_p0.sol = (x == '0);
                    tag_p0.eol = (x == X_LAST);
                    tag_p0.eof = fl_ln && (x == X_LAST);
                end
                if (fl_ln && (x == P_LAST)) state_nxt = S_FIN;
            end
`endif
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Raster counters; the address simply increments across lines.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x    <= '0;
            hb   <= '0;
            y    <= '0;
            addr <= '0;
`ifdef PIXEL_STREAM_TX_FLUSH_EN
            fl_ln <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    x    <= '0;
                    hb   <= '0;
                    y    <= '0;
                    addr <= '0;
`ifdef PIXEL_STREAM_TX_FLUSH_EN
                    fl_ln <= 1'b0;
`endif
                end
                S_LINE: begin
                    addr <= addr + 1'b1;
                    x    <= (x == X_LAST) ? '0 : x + 1'b1;
                end
                S_HBLANK: begin
                    if (hb == H_LAST) begin
                        hb <= '0;
                        if (y != Y_LAST) y <= y + 1'b1;
                    end else begin
                        hb <= hb + 1'b1;
                    end
                end
`ifdef PIXEL_STREAM_TX_FLUSH_EN
                S_FLUSH: begin
                    if (x == P_LAST) begin
                        x     <= '0;
                        fl_ln <= 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.mem_addr = addr;

    // Stage 1: slot tag waits one cycle for the memory read data.
    always_ff @(posedge clk) begin
        if (!rstn) tag_p1 <= '0;
        else       tag_p1 <= tag_p0;
    end

    // Stage 2: registered pixel, zero on blank and flush slots.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_p2   <= '0;
            g_p2   <= '0;
            b_p2   <= '0;
            vld_p2 <= 1'b0;
            mrk_p2 <= '0;
        end else begin
            {r_p2, g_p2, b_p2} <= pix_gate(bus.mem_rdata, tag_p1.vld && !tag_p1.fl);
            vld_p2 <= tag_p1.vld;
            mrk_p2 <= {tag_p1.sof, tag_p1.sol, tag_p1.eol, tag_p1.eof};
        end
    end

    assign bus.dataR     = r_p2;
    assign bus.dataG     = g_p2;
    assign bus.dataB     = b_p2;
    assign bus.pix_valid = vld_p2;
    assign {bus.sof, bus.sol, bus.eol, bus.eof} = mrk_p2;
endmodule

// File: tb/tb_pixel_stream_tx.sv
`timescale 1ns/1ps
// Bench for pixel_stream_tx with a 4x3 image, HBLANK=2 and memory word n = {n,n+1,n+2}.
module tb_pixel_stream_tx;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HB = 2;
    localparam int AW = 4;
`ifdef PIXEL_STREAM_TX_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    localparam int DONE_C = FL ? 31 : 19;
    localparam int EOF_C  = FL ? 30 : 18;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    pixel_stream_tx_if #(.ADDR_W(AW)) bus();

    pixel_stream_tx #(.IMG_W(W), .IMG_H(H), .HBLANK(HB), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame memory: 1-cycle latency, junk on the bus when not read.
    always @(posedge clk) begin
        logic [7:0] a;
        a = 8'(bus.mem_addr);
        if (bus.mem_rd) bus.mem_rdata <= {a, a + 8'd1, a + 8'd2};
        else            bus.mem_rdata <= 24'hA5C3E1;
    end

    typedef struct {
        int          t;
        logic [23:0] rgb;
        logic [3:0]  mk;
    } exp_t;

    exp_t q[$];
    int   sof_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   S = 0;
    int   exp_addr = 0;
    int   rd_cnt = 0;
    int   rd_last = -1;
    int   eof_cyc = -1;
    int   eof_cnt = 0;
    int   rd_cyc[W*H];
    int   dc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each observed read predicts the pixel two cycles later.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (mon_en) begin
            if (q.size() > 0 && q[0].t == cyc) begin
                e = q.pop_front();
                chk("pix_valid", 32'(bus.pix_valid), 32'd1);
                chk("pix_rgb", 32'({bus.dataR, bus.dataG, bus.dataB}), 32'(e.rgb));
                chk("pix_mrk", 32'({bus.sof, bus.sol, bus.eol, bus.eof}), 32'(e.mk));
            end else begin
                chk("blank_vld", 32'(bus.pix_valid), 32'd0);
                chk("blank_rgb", 32'({bus.dataR, bus.dataG, bus.dataB}), 32'd0);
                chk("blank_mrk", 32'({bus.sof, bus.sol, bus.eol, bus.eof}), 32'd0);
            end
            if (bus.pix_valid && bus.sof) sof_q.push_back(cyc);
            if (bus.pix_valid && bus.eof) begin
                eof_cyc = cyc - S;
                eof_cnt++;
            end
            if (!busy) exp_addr = 0;
            if (bus.mem_rd) begin
                chk("rd_addr", 32'(bus.mem_addr), 32'(exp_addr));
                rd_cnt++;
                rd_last = cyc - S;
                if (exp_addr < W*H) rd_cyc[exp_addr] = cyc - S;
                a = int'(bus.mem_addr);
                if (rstn) begin
                    e.t   = cyc + 2;
                    e.rgb = {8'(a), 8'(a + 1), 8'(a + 2)};
                    e.mk  = {a == 0, a % W == 0, a % W == W - 1, !FL && a == W*H - 1};
                    q.push_back(e);
                    if (FL && a == W*H - 1) begin
                        for (int l = 0; l < 2; l++)
                            for (int k = 0; k < W; k++) begin
                                e.t   = cyc + HB + 3 + k + l * (W + HB);
                                e.rgb = 24'd0;
                                e.mk  = {1'b0, k == 0, k == W - 1, l == 1 && k == W - 1};
                                q.push_back(e);
                            end
                    end
                end
                exp_addr++;
            end
            if (!rstn) q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int k);
        while (cyc < S + k) step();
    endtask

    task automatic begin_frame();
        S       = cyc;
        rd_cnt  = 0;
        rd_last = -1;
        eof_cnt = 0;
        eof_cyc = -1;
        start   = 1'b1;
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                d = cyc - S;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_rd", 32'(bus.mem_rd), 32'd0);
            chk("rst_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_vld", 32'(bus.pix_valid), 32'd0);
            chk("rst_rgb", 32'({bus.dataR, bus.dataG, bus.dataB}), 32'd0);
            chk("rst_mrk", 32'({bus.sof, bus.sol, bus.eol, bus.eof}), 32'd0);
            step();
        end
        mon_en = 1'b1;

        // Single frame
        sof_q.delete();
        begin_frame();
        @(negedge clk);
        chk("f1_busy_c0", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("f1_busy_c1", 32'(busy), 32'd1);
        chk("f1_rd_c1", 32'(bus.mem_rd), 32'd1);
        wait_done(dc);
        chk("f1_done_cyc", 32'(dc), 32'(DONE_C));
        chk("f1_busy_done", 32'(busy), 32'd0);
        chk("f1_reads", 32'(rd_cnt), 32'd12);
        chk("f1_last_rd", 32'(rd_last), 32'd16);
        chk("f1_eof_cyc", 32'(eof_cyc), 32'(EOF_C));
        chk("f1_eof_cnt", 32'(eof_cnt), 32'd1);
        chk("f1_sof_cnt", 32'(sof_q.size()), 32'd1);
        if (sof_q.size() > 0) chk("f1_sof_cyc", 32'(sof_q[0] - S), 32'd3);
        for (int a = 0; a < W*H; a++)
            chk("f1_rd_cyc", 32'(rd_cyc[a]), 32'(1 + a + (a / W) * HB));
        step();
        step();

        // start pulses while busy are ignored
        begin_frame();
        step();
        start = 1'b0;
        go_to(5);
        start = 1'b1;
        step();
        start = 1'b0;
        go_to(10);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(dc);
        chk("ign_done_cyc", 32'(dc), 32'(DONE_C));
        chk("ign_reads", 32'(rd_cnt), 32'd12);
        step();
        step();
        @(negedge clk);
        chk("ign_no_restart", 32'(busy), 32'd0);
        step();

        // Reset in the middle of a frame
        begin_frame();
        step();
        start = 1'b0;
        go_to(8);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_vld", 32'(bus.pix_valid), 32'd0);
        chk("mrst_rgb", 32'({bus.dataR, bus.dataG, bus.dataB}), 32'd0);
        chk("mrst_done9", 32'(done), 32'd0);
        step();
        start = 1'b1;
        @(negedge clk);
        chk("mrst_done10", 32'(done), 32'd0);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("mrst_rd11", 32'(bus.mem_rd), 32'd1);
        chk("mrst_addr11", 32'(bus.mem_addr), 32'd0);
        wait_done(dc);
        chk("mrst_done_cyc", 32'(dc), 32'(10 + DONE_C));
        step();
        step();

        // start held high: back-to-back frames
        sof_q.delete();
        begin_frame();
        wait_done(dc);
        chk("held_done1", 32'(dc), 32'(DONE_C));
        step();
        @(negedge clk);
        chk("held_idle_rd", 32'(bus.mem_rd), 32'd0);
        step();
        @(negedge clk);
        chk("held_rd", 32'(bus.mem_rd), 32'd1);
        chk("held_addr", 32'(bus.mem_addr), 32'd0);
        step();
        start = 1'b0;
        wait_done(dc);
        chk("held_done2", 32'(dc), 32'(2 * DONE_C + 1));
        chk("held_sof_cnt", 32'(sof_q.size()), 32'd2);
        if (sof_q.size() == 2) chk("held_sof_gap", 32'(sof_q[1] - sof_q[0]), 32'(DONE_C + 1));
        step();
        step();
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
